lsu: RTL and testbench
======================

# lsu

Load/store unit sitting between the execute stage and the data bus: accepts one memory operation at a time from execute, issues a single outstanding request on a valid/ready data bus, and returns load data, stall, and trap information to execute and CSR. It realigns sub-word stores into bus lanes with byte strobes. It also extracts and extends sub-word load data. Execute holds its operation stable while `lsu_bp_o` is high.

## Interface
- `ADDR_W`, 32, address and PC width
- `DATA_W`, 32, bus data width (fixed 32; other values unsupported)

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  reset; asynchronous, active-high
- `op_typ_i`  in  2  0=NO_LSU, 1=LSU_LOAD, 2=LSU_STORE, 3=reserved (treated as NO_LSU)
- `width_i`  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores use 000/001/010)
- `addr_i`  in  32  effective address
- `wdata_i`  in  32  store data (right-aligned)
- `pc_i`  in  32  PC of the memory instruction
- `lsu_bp_o`  out  1  back-pressure to execute
- `lsu_pc_o`  out  32  PC of the in-flight or last trapped operation
- `ld_valid_o`  out  1  one-cycle pulse: `ld_data_o` valid
- `ld_data_o`  out  32  extended load result
- `trap_active_o`  out  1  one-cycle trap pulse
- `trap_cause_o`  out  4  4 load misaligned, 5 load fault, 6 store misaligned, 7 store fault
- `trap_mtval_o`  out  32  faulting address
- `bus_req_valid_o`  out  1  request valid
- `bus_req_ready_i`  in  1  request accepted
- `bus_req_addr_o`  out  32  word-aligned address (`addr[31:2],2'b00`)
- `bus_req_we_o`  out  1  1 = store
- `bus_req_wdata_o`  out  32  lane-replicated store data
- `bus_req_strb_o`  out  4  byte strobes
- `bus_rsp_valid_i`  in  1  response valid (always accepted)
- `bus_rsp_rdata_i`  in  32  read data
- `bus_rsp_err_i`  in  1  access error

## Operation
- States: IDLE, REQ (request valid, waiting for ready), RESP (waiting for response).
- IDLE, op LOAD/STORE, aligned: register addr/we/wdata/strb/width/pc, go to REQ. Alignment: H needs `addr[0]=0`; W needs `addr[1:0]=0`.
- IDLE, misaligned: no bus access, stay IDLE, `lsu_bp_o=0`. Next cycle: trap pulse, cause 4 or 6, mtval=addr_i, `lsu_pc_o=pc_i`.
- REQ: `bus_req_valid_o=1`, fields constant; on `bus_req_ready_i` go to RESP.
- RESP: on `bus_rsp_valid_i`, go to IDLE.
  - Err: trap pulse next cycle, cause 5/7, mtval = registered full address. No `ld_valid_o`.
  - Else, load: `ld_valid_o` pulse next cycle with `ld_data_o`.
  - Else, store: no further output.
- Store lanes:
  - B: wdata={4{wdata[7:0]}}, strb=4'b0001<<addr[1:0]
  - H: wdata={2{wdata[15:0]}}, strb=4'b0011<<addr[1:0]
  - W: wdata unchanged, strb=4'b1111
- Load extract: byte = rdata >> (8*addr[1:0]); half = rdata >> (16*addr[1]). B/H sign-extend; BU/HU zero-extend; W raw.
- `lsu_bp_o` = (IDLE && valid op && aligned) || REQ || (RESP && !bus_rsp_valid_i). It drops combinationally in the response cycle, so execute advances at that edge. The op presented in the next cycle is treated as new.
- `bus_rsp_valid_i` in IDLE/REQ is ignored. Reserved width codes are treated as W.

## Timing
- Reset (async, any state): state IDLE; all outputs 0; `bus_req_*` 0; `ld_data_o`=0; `lsu_pc_o`=0. A response arriving after reset is dropped.
- Zero-wait bus, load presented at cycle 0:
  - c0: bp=1
  - c1: req_valid=1, ready=1
  - c2: rsp_valid=1, bp=0
  - c3: ld_valid_o=1
- Every extra `bus_req_ready_i`/`bus_rsp_valid_i` wait cycle extends bp by one cycle.
- Trap pulses and `ld_valid_o` are registered, exactly one cycle wide, and never overlap.
- Misaligned op: bp never asserted; trap in c1.

## Test plan
- LW addr 0x100, rdata 0xDEADBEEF, ready/rsp immediate -> bus addr 0x100, we=0; bp high c0–c1, low c2; c3 ld_valid, data 0xDEADBEEF.
- LB addr 0x103, rdata 0x80000000 -> ld_data 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 rdata 0xABCD0000 -> 0x0000ABCD.
- SB addr 0x201, wdata 0x12345678 -> bus addr 0x200, wdata 0x78787878, strb 0010, we=1; SH addr 0x202 -> wdata 0x56785678, strb 1100.
- LH addr 0x301, pc 0x80 -> no bus_req_valid, bp=0, next cycle trap cause 4, mtval 0x301, lsu_pc 0x80; SW addr 0x302 -> cause 6.
- LW with ready held low 3 cycles, then rsp_err=1 -> bp high throughout, request fields stable; trap cause 5, mtval 0x100, no ld_valid.
- Assert rst while in RESP, then rsp_valid arrives after release -> all outputs 0, no ld_valid, state IDLE; next LW completes normally.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: single outstanding request on a valid/ready data bus.
// Stores are lane-replicated with byte strobes; loads are extracted and
// sign/zero-extended from the addressed lane. Misaligned accesses trap
// without touching the bus.
module lsu #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        op_typ_i,
  input  logic [2:0]        width_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              lsu_bp_o,
  output logic [ADDR_W-1:0] lsu_pc_o,
  output logic              ld_valid_o,
  output logic [DATA_W-1:0] ld_data_o,
  output logic              trap_active_o,
  output logic [3:0]        trap_cause_o,
  output logic [ADDR_W-1:0] trap_mtval_o,
  output logic              bus_req_valid_o,
  input  logic              bus_req_ready_i,
  output logic [ADDR_W-1:0] bus_req_addr_o,
  output logic              bus_req_we_o,
  output logic [DATA_W-1:0] bus_req_wdata_o,
  output logic [3:0]        bus_req_strb_o,
  input  logic              bus_rsp_valid_i,
  input  logic [DATA_W-1:0] bus_rsp_rdata_i,
  input  logic              bus_rsp_err_i
);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [2:0]          width_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [3:0]          strb_q;
  logic [ADDR_W-1:0]   pc_q;
  logic                ld_valid_q;
  logic [DATA_W-1:0]   ld_data_q;
  logic                trap_q;
  logic [3:0]          cause_q;
  logic [ADDR_W-1:0]   mtval_q;

  logic                is_load, is_store, op_vld, aligned;
  logic [DATA_W-1:0]   wdata_lane;
  logic [3:0]          strb_lane;
  logic [7:0]          byte_sh;
  logic [15:0]         half_sh;
  logic [DATA_W-1:0]   ld_ext;

  // Decode incoming op: validity, alignment and store lane placement.
  // Size comes from width[1:0]; 11 (reserved) falls through to word.
  always_comb begin
    is_load    = (op_typ_i == 2'd1);
    is_store   = (op_typ_i == 2'd2);
    op_vld     = is_load | is_store;
    aligned    = 1'b1;
    wdata_lane = wdata_i;
    strb_lane  = 4'b1111;
    case (width_i[1:0])
      2'b00: begin
        wdata_lane = {4{wdata_i[7:0]}};
        strb_lane  = 4'b0001 << addr_i[1:0];
      end
      2'b01: begin
        aligned    = ~addr_i[0];
        wdata_lane = {2{wdata_i[15:0]}};
        strb_lane  = 4'b0011 << addr_i[1:0];
      end
      default: begin
        aligned    = (addr_i[1:0] == 2'b00);
      end
    endcase
  end

  // Extract the addressed byte/half from response data and extend it.
  always_comb begin
    byte_sh = 8'(bus_rsp_rdata_i >> {addr_q[1:0], 3'b000});
    half_sh = 16'(bus_rsp_rdata_i >> {addr_q[1], 4'b0000});
    case (width_q[1:0])
      2'b00:   ld_ext = width_q[2] ? {24'b0, byte_sh} : {{24{byte_sh[7]}}, byte_sh};
      2'b01:   ld_ext = width_q[2] ? {16'b0, half_sh} : {{16{half_sh[15]}}, half_sh};
      default: ld_ext = bus_rsp_rdata_i;
    endcase
  end

  // Control FSM with registered request fields, load result and trap pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      width_q    <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      strb_q     <= '0;
      pc_q       <= '0;
      ld_valid_q <= 1'b0;
      ld_data_q  <= '0;
      trap_q     <= 1'b0;
      cause_q    <= '0;
      mtval_q    <= '0;
    end else begin
      ld_valid_q <= 1'b0;
      trap_q     <= 1'b0;
      case (state_q)
        StIdle: begin
          if (op_vld) begin
            pc_q <= pc_i;
            if (aligned) begin
              addr_q  <= addr_i;
              width_q <= width_i;
              we_q    <= is_store;
              wdata_q <= wdata_lane;
              strb_q  <= strb_lane;
              state_q <= StReq;
            end else begin
              trap_q  <= 1'b1;
              cause_q <= is_load ? 4'd4 : 4'd6;
              mtval_q <= addr_i;
            end
          end
        end
        StReq: begin
          if (bus_req_ready_i) state_q <= StResp;
        end
        StResp: begin
          if (bus_rsp_valid_i) begin
            state_q <= StIdle;
            if (bus_rsp_err_i) begin
              trap_q  <= 1'b1;
              cause_q <= we_q ? 4'd7 : 4'd5;
              mtval_q <= addr_q;
            end else if (!we_q) begin
              ld_valid_q <= 1'b1;
              ld_data_q  <= ld_ext;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Back-pressure drops in the response cycle so execute advances on that edge.
  always_comb begin
    lsu_bp_o = ((state_q == StIdle) && op_vld && aligned) ||
               (state_q == StReq) ||
               ((state_q == StResp) && !bus_rsp_valid_i);
  end

  assign bus_req_valid_o = (state_q == StReq);
  assign bus_req_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus_req_we_o    = we_q;
  assign bus_req_wdata_o = wdata_q;
  assign bus_req_strb_o  = strb_q;
  assign lsu_pc_o        = pc_q;
  assign ld_valid_o      = ld_valid_q;
  assign ld_data_o       = ld_data_q;
  assign trap_active_o   = trap_q;
  assign trap_cause_o    = cause_q;
  assign trap_mtval_o    = mtval_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed cases then randomized ops with a behavioural model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  op_typ_i;
  logic [2:0]  width_i;
  logic [31:0] addr_i, wdata_i, pc_i;
  logic        lsu_bp_o;
  logic [31:0] lsu_pc_o;
  logic        ld_valid_o;
  logic [31:0] ld_data_o;
  logic        trap_active_o;
  logic [3:0]  trap_cause_o;
  logic [31:0] trap_mtval_o;
  logic        bus_req_valid_o, bus_req_ready_i;
  logic [31:0] bus_req_addr_o;
  logic        bus_req_we_o;
  logic [31:0] bus_req_wdata_o;
  logic [3:0]  bus_req_strb_o;
  logic        bus_rsp_valid_i;
  logic [31:0] bus_rsp_rdata_i;
  logic        bus_rsp_err_i;

  int total = 0;
  int bad   = 0;

  lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .op_typ_i        (op_typ_i),
    .width_i         (width_i),
    .addr_i          (addr_i),
    .wdata_i         (wdata_i),
    .pc_i            (pc_i),
    .lsu_bp_o        (lsu_bp_o),
    .lsu_pc_o        (lsu_pc_o),
    .ld_valid_o      (ld_valid_o),
    .ld_data_o       (ld_data_o),
    .trap_active_o   (trap_active_o),
    .trap_cause_o    (trap_cause_o),
    .trap_mtval_o    (trap_mtval_o),
    .bus_req_valid_o (bus_req_valid_o),
    .bus_req_ready_i (bus_req_ready_i),
    .bus_req_addr_o  (bus_req_addr_o),
    .bus_req_we_o    (bus_req_we_o),
    .bus_req_wdata_o (bus_req_wdata_o),
    .bus_req_strb_o  (bus_req_strb_o),
    .bus_rsp_valid_i (bus_rsp_valid_i),
    .bus_rsp_rdata_i (bus_rsp_rdata_i),
    .bus_rsp_err_i   (bus_rsp_err_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Access size in bytes from funct3; reserved codes act as word.
  function automatic int unsigned nbytes(input logic [2:0] w);
    if (w == 3'd0 || w == 3'd4) return 1;
    if (w == 3'd1 || w == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] w, input logic [31:0] a,
                                           input logic [31:0] rd);
    int unsigned n = nbytes(w);
    longint v;
    longint lim;
    if (n == 4) return rd;
    lim = longint'(1) << (8 * n);
    v   = (longint'(rd) >> (8 * (a % 4))) % lim;
    if ((w == 3'd0 || w == 3'd1) && v >= lim / 2) v = v - lim;
    return v[31:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] w, input logic [31:0] wd);
    int unsigned n = nbytes(w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [3:0] exp_strb(input logic [2:0] w, input logic [31:0] a);
    int unsigned n = nbytes(w);
    int unsigned m = ((1 << n) - 1) << (a % 4);
    return m[3:0];
  endfunction

  // One full operation from execute, with a bus model of rw ready-wait and sw rsp-wait cycles.
  task automatic do_op(input logic [1:0] op, input logic [2:0] w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] pcv, input logic [31:0] rd,
                       input int rw, input int sw, input logic err);
    logic ld;
    logic al;
    ld = (op == 2'd1);
    al = ((a % nbytes(w)) == 0);
    @(negedge clk);
    op_typ_i = op; width_i = w; addr_i = a; wdata_i = wd; pc_i = pcv;
    bus_req_ready_i = 1'b0; bus_rsp_valid_i = 1'b0; bus_rsp_err_i = 1'b0;
    #1;
    if (!al) begin
      chk("mis_bp", lsu_bp_o, 0);
      chk("mis_reqv", bus_req_valid_o, 0);
      @(negedge clk);
      op_typ_i = 2'd0;
      #1;
      chk("mis_trap", trap_active_o, 1);
      chk("mis_cause", trap_cause_o, ld ? 4 : 6);
      chk("mis_mtval", trap_mtval_o, a);
      chk("mis_pc", lsu_pc_o, pcv);
      chk("mis_ldv", ld_valid_o, 0);
      chk("mis_reqv2", bus_req_valid_o, 0);
      @(negedge clk);
      #1;
      chk("mis_trap_off", trap_active_o, 0);
      return;
    end
    chk("bp_c0", lsu_bp_o, 1);
    for (int i = 0; i <= rw; i++) begin
      @(negedge clk);
      bus_req_ready_i = (i == rw);
      #1;
      chk("req_valid", bus_req_valid_o, 1);
      chk("req_bp", lsu_bp_o, 1);
      chk("req_addr", bus_req_addr_o, {a[31:2], 2'b00});
      chk("req_we", bus_req_we_o, !ld);
      chk("req_pc", lsu_pc_o, pcv);
      if (!ld) begin
        chk("req_wdata", bus_req_wdata_o, exp_wdata(w, wd));
        chk("req_strb", bus_req_strb_o, exp_strb(w, a));
      end
    end
    for (int i = 0; i <= sw; i++) begin
      @(negedge clk);
      bus_req_ready_i = 1'b0;
      bus_rsp_valid_i = (i == sw);
      bus_rsp_err_i   = (i == sw) ? err : 1'b0;
      bus_rsp_rdata_i = (i == sw) ? rd : $urandom;
      #1;
      chk("rsp_bp", lsu_bp_o, (i != sw));
      chk("rsp_reqv", bus_req_valid_o, 0);
    end
    @(negedge clk);
    bus_rsp_valid_i = 1'b0; bus_rsp_err_i = 1'b0; op_typ_i = 2'd0;
    #1;
    chk("done_ldv", ld_valid_o, ld && !err);
    if (ld && !err) chk("done_ldata", ld_data_o, exp_load(w, a, rd));
    chk("done_trap", trap_active_o, err);
    if (err) begin
      chk("done_cause", trap_cause_o, ld ? 5 : 7);
      chk("done_mtval", trap_mtval_o, a);
    end
    @(negedge clk);
    #1;
    chk("post_ldv", ld_valid_o, 0);
    chk("post_trap", trap_active_o, 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_bp"}, lsu_bp_o, 0);
    chk({tag, "_pc"}, lsu_pc_o, 0);
    chk({tag, "_ldv"}, ld_valid_o, 0);
    chk({tag, "_ldd"}, ld_data_o, 0);
    chk({tag, "_trap"}, trap_active_o, 0);
    chk({tag, "_cause"}, trap_cause_o, 0);
    chk({tag, "_mtval"}, trap_mtval_o, 0);
    chk({tag, "_reqv"}, bus_req_valid_o, 0);
    chk({tag, "_addr"}, bus_req_addr_o, 0);
    chk({tag, "_we"}, bus_req_we_o, 0);
    chk({tag, "_wdata"}, bus_req_wdata_o, 0);
    chk({tag, "_strb"}, bus_req_strb_o, 0);
  endtask

  initial begin
    logic [1:0]  op;
    logic [2:0]  w;
    logic [31:0] a;
    rst = 1'b1;
    op_typ_i = 2'd0; width_i = 3'd0; addr_i = '0; wdata_i = '0; pc_i = '0;
    bus_req_ready_i = 1'b0; bus_rsp_valid_i = 1'b0; bus_rsp_rdata_i = '0; bus_rsp_err_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outs("rst");
    rst = 1'b0;

    // Directed cases.
    do_op(2'd1, 3'd2, 32'h100, 32'h0, 32'h10, 32'hDEADBEEF, 0, 0, 1'b0);
    do_op(2'd1, 3'd0, 32'h103, 32'h0, 32'h14, 32'h80000000, 0, 0, 1'b0);
    do_op(2'd1, 3'd4, 32'h103, 32'h0, 32'h18, 32'h80000000, 0, 0, 1'b0);
    do_op(2'd1, 3'd5, 32'h102, 32'h0, 32'h1C, 32'hABCD0000, 0, 0, 1'b0);
    do_op(2'd2, 3'd0, 32'h201, 32'h12345678, 32'h20, 32'h0, 0, 0, 1'b0);
    do_op(2'd2, 3'd1, 32'h202, 32'h12345678, 32'h24, 32'h0, 0, 0, 1'b0);
    do_op(2'd1, 3'd1, 32'h301, 32'h0, 32'h80, 32'h0, 0, 0, 1'b0);
    do_op(2'd2, 3'd2, 32'h302, 32'h0, 32'h84, 32'h0, 0, 0, 1'b0);
    do_op(2'd1, 3'd2, 32'h100, 32'h0, 32'h88, 32'h0, 3, 0, 1'b1);
    do_op(2'd2, 3'd2, 32'h400, 32'hCAFEF00D, 32'h8C, 32'h0, 1, 2, 1'b1);

    // Reset while waiting for a response; the late response must be dropped.
    @(negedge clk);
    op_typ_i = 2'd1; width_i = 3'd2; addr_i = 32'h100; pc_i = 32'h90;
    @(negedge clk);
    bus_req_ready_i = 1'b1;
    @(negedge clk);
    bus_req_ready_i = 1'b0;
    #1;
    chk("resp_bp", lsu_bp_o, 1);
    op_typ_i = 2'd0;
    rst = 1'b1;
    #1;
    chk_reset_outs("arst");
    @(negedge clk);
    rst = 1'b0;
    bus_rsp_valid_i = 1'b1; bus_rsp_rdata_i = 32'h11223344;
    @(negedge clk);
    bus_rsp_valid_i = 1'b0;
    #1;
    chk("late_ldv", ld_valid_o, 0);
    chk("late_trap", trap_active_o, 0);
    chk("late_reqv", bus_req_valid_o, 0);
    chk("late_bp", lsu_bp_o, 0);
    do_op(2'd1, 3'd2, 32'h100, 32'h0, 32'h94, 32'h55AA55AA, 0, 0, 1'b0);

    // Randomized ops.
    for (int k = 0; k < 150; k++) begin
      op = ($urandom_range(0, 1) == 0) ? 2'd1 : 2'd2;
      if (op == 2'd1) begin
        case ($urandom_range(0, 5))
          0: w = 3'd0;
          1: w = 3'd1;
          2: w = 3'd2;
          3: w = 3'd4;
          4: w = 3'd5;
          default: w = 3'd3;
        endcase
      end else begin
        w = 3'($urandom_range(0, 2));
      end
      a = $urandom;
      do_op(op, w, a, $urandom, $urandom, $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
